// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and occupancy width shared by pipeline stages
package pipe_pkg;
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_t;
  localparam int OCC_W = 2;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: stallable pipeline register with two-entry skid buffer and registered ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);
  pipe_state_t state, state_n;
  logic [WIDTH-1:0] main_q, skid_q;
  logic in_fire, out_fire, load_main, load_skid, from_skid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = state != PIPE_EMPTY;
  assign out_data  = main_q;
  assign occupancy = state;
  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    case (state)
      PIPE_EMPTY: begin
        state_n   = in_fire ? PIPE_BUSY : PIPE_EMPTY;
        load_main = in_fire;
      end
      PIPE_BUSY: begin
        state_n   = (in_fire && !out_fire) ? PIPE_FULL : (!in_fire && out_fire) ? PIPE_EMPTY : PIPE_BUSY;
        load_main = in_fire && out_fire;
        load_skid = in_fire && !out_fire;
      end
      PIPE_FULL: begin
        state_n   = out_fire ? PIPE_BUSY : PIPE_FULL;
        load_main = out_fire;
        from_skid = 1'b1;
      end
      default: state_n = PIPE_EMPTY;
    endcase
    if (flush) begin
      state_n   = PIPE_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PIPE_EMPTY;
      in_ready <= 1'b1;
      main_q   <= DEFAULT;
      skid_q   <= DEFAULT;
    end else begin
      state    <= state_n;
      in_ready <= state_n != PIPE_FULL;
      if (load_main) main_q <= from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Stallable pipeline register with a two-entry skid buffer and valid/ready handshake.
- Sits directly downstream of the fixed-latency delay lines. It takes a delayed result plus its valid flag and presents it to the next CPU stage, which may stall.
- All outputs are registered, so no combinational path runs from out_ready to in_ready. This lets long stall chains meet timing.

Parameters:
- WIDTH, 32, payload width in bits.
- DEFAULT, 0, value loaded into the main and skid data registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream has data this cycle.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  block accepts data this cycle; registered.
- out_valid  output  1  out_data is valid.
- out_data  output  WIDTH  payload at the head of the block.
- out_ready  input  1  downstream consumes this cycle.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=DEFAULT, occupancy=0; skid data=DEFAULT; state=EMPTY.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Transfers complete on the rising edge where fire=1.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. in_valid may drop without a transfer.
- States: EMPTY (occ 0), BUSY (main valid, occ 1), FULL (main and skid valid, occ 2).
- in_ready = (state != FULL), registered from next-state. out_valid = (state != EMPTY).
- EMPTY:
  - in_fire -> BUSY, main <= in_data.
  - otherwise stay EMPTY.
- BUSY:
  - in_fire & out_fire -> BUSY, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - otherwise stay BUSY.
- FULL:
  - in_ready=0, so in_fire is impossible.
  - out_fire -> BUSY, main <= skid.
  - otherwise stay FULL.
- Latency: data accepted at edge N appears on out_data after edge N, i.e. one cycle, when the block is EMPTY or drains every cycle.
- Throughput: one transfer per cycle when out_ready is held high.
- Ordering: strict FIFO; the skid entry is never presented ahead of main.
- Flush:
  - Priority below rst and above everything else.
  - Next state is EMPTY, occupancy 0, in_ready 1 on the following cycle.
  - An in_fire coinciding with flush is dropped. An out_fire coinciding with flush still counts as consumed downstream.
  - Data registers hold their last values.
- Reset mid-operation: same as flush, plus data registers load DEFAULT.
- out_data while out_valid=0 is don't-care for consumers but is deterministic: it equals the last main value.
- A FULL state with out_ready low holds indefinitely; nothing is lost or overwritten.
- occupancy always equals main_valid + skid_valid. No illegal encodings are reachable; any illegal state code recovers to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg holds the 2-bit state encoding constants: PIPE_EMPTY=0, PIPE_BUSY=1, PIPE_FULL=2.
- The package also holds the occupancy width constant, so hazard/stall logic in other stages can decode occupancy.
- No sub-module. The block stays flat: a state register, two data registers and a registered ready.
- Chains of stages instantiate pipe_skid_reg repeatedly; a delay instance may precede it.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> in_ready=1, out_valid=0, out_data=DEFAULT, occupancy=0.
- Streaming: out_ready=1, send 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle after each is accepted; occupancy stays at 1.
- Stall fill: out_ready=0, send 0xA1 then 0xA2 -> occupancy goes 1 then 2, in_ready=0 after the second edge, and 0xA3 held on in_data is not accepted. Then raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order with no loss or duplication.
- Drain from FULL: hold FULL, pulse out_ready for 1 cycle -> out_data becomes the skid value, occupancy=1, in_ready=1 the next cycle.
- Flush: with occupancy=2, assert flush with in_valid=1 and in_data=0x55 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x55 never appears at the output.
- Random: random in_valid and out_ready for 10k cycles with a scoreboard model -> identical ordered sequence, in_ready never 1 while occupancy=2, occupancy always 0..2.
